spi_host_cmd: RTL and testbench

SPI_HOST_CMD -- requirements
Module: spi_host_cmd

---
 rtl/spi_host_cmd.sv | 171 +++++++++++++++++
 tb/tb_spi_host_cmd.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_host_cmd.sv
`default_nettype none
// spi_host_cmd: sends a 32-bit SPI command header, waits for the target's ready
// strobe, then optionally reads one byte back. Rev 1.0
module spi_host_cmd #(
  parameter int SCLK_HALF     = 4,
  parameter int READY_TIMEOUT = 1024,
  parameter int CS_IDLE       = 4
) (
  input  logic        clk_sys_i,
  input  logic        reset_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_rw_ni,
  input  logic [16:0] cmd_addr_i,
  input  logic [7:0]  cmd_data_i,
  output logic        rsp_valid_o,
  output logic [7:0]  rsp_data_o,
  output logic        rsp_timeout_o,
  output logic        spi_sclk_o,
  output logic        spi_cs_no,
  output logic        spi_tx_o,
  input  logic        spi_rx_i,
  input  logic        spi_ready_ni
);

  localparam int WAIT_W = $clog2(READY_TIMEOUT + 1);
  localparam int GAP_W  = $clog2(CS_IDLE + 1);
  localparam logic [7:0]        HALF_LAST = 8'(SCLK_HALF - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READY_TIMEOUT - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(CS_IDLE - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_HDR   = 3'd2,
    S_WAIT  = 3'd3,
    S_RD    = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  state_t            state;
  logic [7:0]        half_cnt;
  logic [4:0]        bit_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [31:0]       tx_shift;
  logic [7:0]        rx_shift;
  logic              rd_cmd;
  logic              rdy_meta;
  logic              rdy_sync;
  logic [31:0]       header;
  logic [4:0]        last_bit;

  assign header   = {cmd_rw_ni, 6'b0, cmd_addr_i[16], cmd_addr_i[15:0],
                     (cmd_rw_ni ? 8'h00 : cmd_data_i)};
  assign last_bit = (state == S_HDR) ? 5'd31 : 5'd7;

  always_ff @(posedge clk_sys_i) begin
    if (reset_i) begin
      state         <= S_IDLE;
      half_cnt      <= '0;
      bit_cnt       <= '0;
      wait_cnt      <= '0;
      gap_cnt       <= '0;
      tx_shift      <= '0;
      rx_shift      <= '0;
      rd_cmd        <= 1'b0;
      rdy_meta      <= 1'b1;
      rdy_sync      <= 1'b1;
      cmd_ready_o   <= 1'b1;
      rsp_valid_o   <= 1'b0;
      rsp_data_o    <= 8'h00;
      rsp_timeout_o <= 1'b0;
      spi_sclk_o    <= 1'b0;
      spi_cs_no     <= 1'b1;
      spi_tx_o      <= 1'b0;
    end else begin
      rdy_meta    <= spi_ready_ni;
      rdy_sync    <= rdy_meta;
      rsp_valid_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid_i && cmd_ready_o) begin
            state       <= S_SETUP;
            cmd_ready_o <= 1'b0;
            spi_cs_no   <= 1'b0;
            spi_tx_o    <= header[31];
            tx_shift    <= header;
            rd_cmd      <= cmd_rw_ni;
            half_cnt    <= '0;
            bit_cnt     <= '0;
          end
        end
        S_SETUP: begin
          if (half_cnt == HALF_LAST) begin
            half_cnt <= '0;
            state    <= S_HDR;
          end else begin
            half_cnt <= half_cnt + 8'd1;
          end
        end
        S_HDR, S_RD: begin
          if (half_cnt != HALF_LAST) begin
            half_cnt <= half_cnt + 8'd1;
          end else begin
            half_cnt <= '0;
            if (!spi_sclk_o) begin
              spi_sclk_o <= 1'b1;
              rx_shift   <= {rx_shift[6:0], spi_rx_i};
            end else begin
              spi_sclk_o <= 1'b0;
              if (bit_cnt != last_bit) begin
                // MOSI only moves here, at the start of a low half
                bit_cnt  <= bit_cnt + 5'd1;
                tx_shift <= {tx_shift[30:0], 1'b0};
                spi_tx_o <= tx_shift[30];
              end else if (state == S_HDR) begin
                bit_cnt  <= '0;
                tx_shift <= '0;
                spi_tx_o <= 1'b0;
                wait_cnt <= '0;
                state    <= S_WAIT;
              end else begin
                state         <= S_GAP;
                gap_cnt       <= '0;
                spi_cs_no     <= 1'b1;
                rsp_valid_o   <= 1'b1;
                rsp_timeout_o <= 1'b0;
                rsp_data_o    <= rx_shift;
              end
            end
          end
        end
        S_WAIT: begin
          if (!rdy_sync) begin
            if (rd_cmd) begin
              state    <= S_RD;
              half_cnt <= '0;
              bit_cnt  <= '0;
            end else begin
              state         <= S_GAP;
              gap_cnt       <= '0;
              spi_cs_no     <= 1'b1;
              rsp_valid_o   <= 1'b1;
              rsp_timeout_o <= 1'b0;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            state         <= S_GAP;
            gap_cnt       <= '0;
            spi_cs_no     <= 1'b1;
            rsp_valid_o   <= 1'b1;
            rsp_timeout_o <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state       <= S_IDLE;
            cmd_ready_o <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_host_cmd.sv
`timescale 1ns/1ps
`default_nettype none
// tb_spi_host_cmd: directed checks of spi_host_cmd against a small SPI target model.
module tb_spi_host_cmd;
  localparam int RT  = 1024;
  localparam int CSI = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        cmd_valid = 1'b0;
  logic        cmd_rw    = 1'b0;
  logic [16:0] cmd_addr  = '0;
  logic [7:0]  cmd_data  = '0;
  logic        cmd_ready, rsp_valid, rsp_timeout, sclk, cs_n, tx;
  logic [7:0]  rsp_data;
  logic        rx = 1'b0, rdy_n = 1'b1;

  logic        valid2 = 1'b0;
  logic        cmd_ready2, rsp_valid2, rsp_timeout2, sclk2, cs_n2, tx2;
  logic [7:0]  rsp_data2;
  logic        rx2 = 1'b0, rdy_n2 = 1'b1;

  spi_host_cmd #(.SCLK_HALF(4), .READY_TIMEOUT(RT), .CS_IDLE(CSI)) u_dut (
    .clk_sys_i(clk), .reset_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_rw_ni(cmd_rw), .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_timeout_o(rsp_timeout),
    .spi_sclk_o(sclk), .spi_cs_no(cs_n), .spi_tx_o(tx), .spi_rx_i(rx), .spi_ready_ni(rdy_n));

  spi_host_cmd #(.SCLK_HALF(2), .READY_TIMEOUT(64), .CS_IDLE(2)) u_dut2 (
    .clk_sys_i(clk), .reset_i(rst), .cmd_valid_i(valid2), .cmd_ready_o(cmd_ready2),
    .cmd_rw_ni(cmd_rw), .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data),
    .rsp_valid_o(rsp_valid2), .rsp_data_o(rsp_data2), .rsp_timeout_o(rsp_timeout2),
    .spi_sclk_o(sclk2), .spi_cs_no(cs_n2), .spi_tx_o(tx2), .spi_rx_i(rx2), .spi_ready_ni(rdy_n2));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Target model and frame monitor for u_dut, sampled just after each rising edge.
  int cyc = 0, rise_cnt = 0, wait_start = -1, rsp_cnt = 0, rsp_cyc = -1;
  int rdy_delay = -1, rdy_cnt = 0, cs_hi_len = 0, last_gap = 0, frames = 0;
  int mosi_bad = 0, busy_ready = 0;
  bit rdy_arm = 1'b0;
  logic [39:0] mosi = '0;
  logic [7:0]  miso_byte = '0;
  logic prev_sclk = 1'b0, prev_tx = 1'b0, prev_cs = 1'b1, rsp_to = 1'b0;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (prev_cs && !cs_n) begin
      rise_cnt = 0;
      mosi     = '0;
      frames++;
      last_gap = cs_hi_len;
    end
    cs_hi_len = cs_n ? cs_hi_len + 1 : 0;
    if (sclk && !prev_sclk) begin
      rise_cnt++;
      mosi = {mosi[38:0], tx};
      if (tx !== prev_tx) mosi_bad++;
    end
    if (!sclk && prev_sclk && rise_cnt == 32) begin
      wait_start = cyc;
      rdy_arm    = 1'b1;
      rdy_cnt    = 0;
    end else if (rdy_arm) begin
      rdy_cnt++;
      if (rdy_cnt == rdy_delay) rdy_n = 1'b0;
      if (rdy_cnt == rdy_delay + 3) begin
        rdy_n   = 1'b1;
        rdy_arm = 1'b0;
      end
    end
    rx = (rise_cnt >= 32 && rise_cnt < 40) ? miso_byte[39 - rise_cnt] : 1'b0;
    if (rsp_valid) begin
      rsp_cnt++;
      rsp_cyc = cyc;
      rsp_to  = rsp_timeout;
    end
    if (cmd_ready && !cs_n) busy_ready++;
    prev_sclk = sclk;
    prev_tx   = tx;
    prev_cs   = cs_n;
  end

  // SCLK period / MOSI stability monitor for u_dut2.
  int cyc2 = 0, rise2 = 0, last_rise2 = 0, per2_bad = 0, stab2_bad = 0, rsp2_cnt = 0;
  logic [31:0] mosi2 = '0;
  logic prev_sclk2 = 1'b0, prev_tx2 = 1'b0, prev_cs2 = 1'b1, rsp2_to = 1'b0;

  always @(posedge clk) begin
    #1;
    cyc2++;
    if (prev_cs2 && !cs_n2) begin
      rise2 = 0;
      mosi2 = '0;
    end
    if (sclk2 && !prev_sclk2) begin
      if (rise2 > 0 && cyc2 - last_rise2 != 4) per2_bad++;
      if (tx2 !== prev_tx2) stab2_bad++;
      rise2++;
      last_rise2 = cyc2;
      mosi2 = {mosi2[30:0], tx2};
    end
    if (rsp_valid2) begin
      rsp2_cnt++;
      rsp2_to = rsp_timeout2;
    end
    prev_sclk2 = sclk2;
    prev_tx2   = tx2;
    prev_cs2   = cs_n2;
  end

  task automatic issue(input logic rw, input logic [16:0] a, input logic [7:0] d, input string tag);
    int k = 0;
    @(negedge clk);
    cmd_rw = rw; cmd_addr = a; cmd_data = d; cmd_valid = 1'b1;
    while (!cmd_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    check_eq({tag, "_cs_low"}, cs_n, 1'b0);
    check_eq({tag, "_tx_bit31"}, tx, rw);
  endtask

  task automatic wait_rsp(input int target, input int limit, input string tag);
    int k = 0;
    while (rsp_cnt < target && k < limit) begin
      @(negedge clk);
      k++;
    end
    check_eq({tag, "_rsp_seen"}, rsp_cnt >= target, 1'b1);
  endtask

  initial begin
    int k;
    int f0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_cs_n", cs_n, 1'b1);
    check_eq("rst_sclk", sclk, 1'b0);
    check_eq("rst_tx", tx, 1'b0);
    check_eq("rst_ready", cmd_ready, 1'b1);
    check_eq("rst_rsp_valid", rsp_valid, 1'b0);
    check_eq("rst_rsp_timeout", rsp_timeout, 1'b0);
    check_eq("rst_rsp_data", rsp_data, 8'h00);

    // Write, ready strobe 20 cycles into WAIT
    rdy_delay = 20;
    issue(1'b0, 17'h08000, 8'hA5, "wr");
    wait_rsp(1, 1000, "wr");
    check_eq("wr_header", mosi[31:0], 32'h008000A5);
    check_eq("wr_rises", rise_cnt, 32);
    check_eq("wr_latency", rsp_cyc - wait_start, 23);
    check_eq("wr_timeout", rsp_to, 1'b0);
    check_eq("wr_rsp_data", rsp_data, 8'h00);
    check_eq("wr_cs_high", cs_n, 1'b1);
    repeat (10) @(negedge clk);
    check_eq("wr_one_pulse", rsp_cnt, 1);

    // Read returning 8'h3C
    rdy_delay = 5;
    miso_byte = 8'h3C;
    issue(1'b1, 17'h1E80F, 8'hFF, "rd");
    wait_rsp(2, 1000, "rd");
    check_eq("rd_header", mosi[39:8], 32'h81E80F00);
    check_eq("rd_mosi_zero", mosi[7:0], 8'h00);
    check_eq("rd_rises", rise_cnt, 40);
    check_eq("rd_data", rsp_data, 8'h3C);
    check_eq("rd_timeout", rsp_to, 1'b0);
    check_eq("rd_mosi_stable", mosi_bad, 0);

    // Read with ready never asserted
    rdy_delay = -1;
    issue(1'b1, 17'h00123, 8'h00, "to");
    wait_rsp(3, 3000, "to");
    check_eq("to_latency", rsp_cyc - wait_start, RT);
    check_eq("to_flag", rsp_to, 1'b1);
    check_eq("to_rsp_data", rsp_data, 8'h3C);
    check_eq("to_cs_high", cs_n, 1'b1);
    check_eq("to_header", mosi[31:0], 32'h80012300);
    check_eq("to_rises", rise_cnt, 32);

    // Reset in the middle of a header
    rdy_delay = 4;
    issue(1'b1, 17'h00055, 8'h00, "mr");
    k = 0;
    while (rise_cnt < 17 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check_eq("mr_reached_bit17", rise_cnt, 17);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mr_cs_n", cs_n, 1'b1);
    check_eq("mr_sclk", sclk, 1'b0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check_eq("mr_no_rsp", rsp_cnt, 3);
    check_eq("mr_ready", cmd_ready, 1'b1);

    rdy_delay = 3;
    issue(1'b0, 17'h1FFFF, 8'h5A, "pr");
    wait_rsp(4, 1000, "pr");
    check_eq("pr_header", mosi[31:0], 32'h01FFFF5A);
    check_eq("pr_timeout", rsp_to, 1'b0);
    check_eq("pr_rises", rise_cnt, 32);

    // Back-to-back with cmd_valid held high
    rdy_delay = 2;
    @(negedge clk);
    f0 = frames;
    cmd_rw = 1'b0; cmd_addr = 17'h00001; cmd_data = 8'h0F; cmd_valid = 1'b1;
    wait_rsp(6, 2000, "b2b");
    cmd_valid = 1'b0;
    check_eq("b2b_frames", frames - f0, 2);
    check_eq("b2b_cs_gap", last_gap, CSI + 1);
    check_eq("b2b_busy_ready", busy_ready, 0);
    check_eq("b2b_header", mosi[31:0], 32'h0000010F);
    repeat (20) @(negedge clk);
    check_eq("b2b_no_third", frames - f0, 2);
    check_eq("b2b_mosi_stable", mosi_bad, 0);

    // SCLK_HALF=2 instance: write, target never ready
    @(negedge clk);
    cmd_rw = 1'b0; cmd_addr = 17'h0ABCD; cmd_data = 8'h3C; valid2 = 1'b1;
    @(negedge clk);
    valid2 = 1'b0;
    k = 0;
    while (rsp2_cnt < 1 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check_eq("h2_rsp_seen", rsp2_cnt, 1);
    check_eq("h2_rises", rise2, 32);
    check_eq("h2_period", per2_bad, 0);
    check_eq("h2_mosi_stable", stab2_bad, 0);
    check_eq("h2_timeout", rsp2_to, 1'b1);
    check_eq("h2_header", mosi2, 32'h00ABCD3C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
